// File: rtl/asap_cu_if.sv
// Host/datapath signal bundle for the ASAP control unit.
// master = host side, slave = control unit side.
interface asap_cu_if;
  logic       start;
  logic       in_ready;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic       in0_oe;
  logic       in1_oe;
  logic       f1_oe;
  logic       f2_oe;
  logic       out_oe;
  logic       r2_sel;
  logic       r1_en;
  logic       r2_en;
  logic       r3_en;
  logic [3:0] f1_f;
  logic [1:0] f2_f;

  modport master (
    output start, out_ready,
    input  in_ready, busy, out_valid, in0_oe, in1_oe, f1_oe, f2_oe, out_oe,
           r2_sel, r1_en, r2_en, r3_en, f1_f, f2_f
  );

  modport slave (
    input  start, out_ready,
    output in_ready, busy, out_valid, in0_oe, in1_oe, f1_oe, f2_oe, out_oe,
           r2_sel, r1_en, r2_en, r3_en, f1_f, f2_f
  );
endinterface

// File: rtl/asap_cu.sv
// ASAP datapath control unit: Moore FSM LOAD -> (EXEC1,EXEC2) x ITER -> OUT.
// Optional abort input enabled by defining ASAP_CU_ABORT_EN.
module asap_cu #(
  parameter int unsigned ITER    = 1,
  parameter logic [3:0]  F1_OP_A = 4'd0,
  parameter logic [3:0]  F1_OP_B = 4'd1,
  parameter logic [1:0]  F2_OP   = 2'd0
) (
  input  logic      clk,
  input  logic      rst,
`ifdef ASAP_CU_ABORT_EN
  input  logic      abort,
`endif
  asap_cu_if.slave  bus
);

  localparam int unsigned    ITER_EFF = (ITER == 0) ? 1 : ITER;
  localparam int unsigned    CW       = $clog2(ITER_EFF) + 1;
  localparam logic [CW-1:0]  LAST     = CW'(ITER_EFF - 1);

  typedef enum logic [2:0] {IDLE, LOAD, EXEC1, EXEC2, OUT} state_t;

  typedef struct packed {
    logic       in_ready;
    logic       busy;
    logic       out_valid;
    logic       in0_oe;
    logic       in1_oe;
    logic       f1_oe;
    logic       f2_oe;
    logic       out_oe;
    logic       r2_sel;
    logic       r1_en;
    logic       r2_en;
    logic       r3_en;
    logic [3:0] f1_f;
    logic [1:0] f2_f;
  } ctrl_t;

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  ctrl_t         ctrl;

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      IDLE:  c.in_ready = 1'b1;
      LOAD: begin
        c.busy   = 1'b1;
        c.in0_oe = 1'b1;
        c.in1_oe = 1'b1;
        c.r1_en  = 1'b1;
        c.r2_en  = 1'b1;
        c.r3_en  = 1'b1;
      end
      EXEC1: begin
        c.busy  = 1'b1;
        c.f1_oe = 1'b1;
        c.f1_f  = F1_OP_A;
        c.r3_en = 1'b1;
        c.f2_oe = 1'b1;
        c.f2_f  = F2_OP;
        c.r2_en = 1'b1;
      end
      EXEC2: begin
        c.busy  = 1'b1;
        c.f1_oe = 1'b1;
        c.f1_f  = F1_OP_B;
        c.r1_en = 1'b1;
      end
      OUT: begin
        c.busy      = 1'b1;
        c.out_valid = 1'b1;
        c.out_oe    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.start) nxt = LOAD;
      LOAD:    nxt = EXEC1;
      EXEC1:   nxt = EXEC2;
      EXEC2:   nxt = (cnt == LAST) ? OUT : EXEC1;
      OUT:     if (bus.out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
`ifdef ASAP_CU_ABORT_EN
    if (abort && state != IDLE) nxt = IDLE;
`endif
  end

  // Outputs are registered from the next state so they always match the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ctrl  <= decode(IDLE);
    end else begin
      state <= nxt;
      ctrl  <= decode(nxt);
      if (state == LOAD)
        cnt <= '0;
      else if (state == EXEC2 && nxt == EXEC1)
        cnt <= cnt + 1'b1;
    end
  end

  assign bus.in_ready  = ctrl.in_ready;
  assign bus.busy      = ctrl.busy;
  assign bus.out_valid = ctrl.out_valid;
  assign bus.in0_oe    = ctrl.in0_oe;
  assign bus.in1_oe    = ctrl.in1_oe;
  assign bus.f1_oe     = ctrl.f1_oe;
  assign bus.f2_oe     = ctrl.f2_oe;
  assign bus.out_oe    = ctrl.out_oe;
  assign bus.r2_sel    = ctrl.r2_sel;
  assign bus.r1_en     = ctrl.r1_en;
  assign bus.r2_en     = ctrl.r2_en;
  assign bus.r3_en     = ctrl.r3_en;
  assign bus.f1_f      = ctrl.f1_f;
  assign bus.f2_f      = ctrl.f2_f;

endmodule

// File: tb/tb_asap_cu.sv
// Bench for asap_cu: ITER=1 and ITER=3 instances checked cycle by cycle
// against a schedule-position model of the control sequence.
module tb_asap_cu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic out_ready = 1'b1;
  logic abort = 1'b0;
  logic sel = 1'b0;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  asap_cu_if i1 ();
  asap_cu_if i3 ();

  assign i1.start     = sel ? 1'b0 : start;
  assign i1.out_ready = sel ? 1'b1 : out_ready;
  assign i3.start     = sel ? start : 1'b0;
  assign i3.out_ready = sel ? out_ready : 1'b1;

  asap_cu u1 (
    .clk   (clk),
    .rst   (rst),
`ifdef ASAP_CU_ABORT_EN
    .abort (sel ? 1'b0 : abort),
`endif
    .bus   (i1)
  );

  asap_cu #(.ITER(3), .F1_OP_A(4'd0), .F1_OP_B(4'd1), .F2_OP(2'd0)) u3 (
    .clk   (clk),
    .rst   (rst),
`ifdef ASAP_CU_ABORT_EN
    .abort (sel ? abort : 1'b0),
`endif
    .bus   (i3)
  );

  logic [17:0] w1, w3, obs;
  logic        excl;

  assign w1 = {i1.in_ready, i1.busy, i1.out_valid, i1.in0_oe, i1.in1_oe, i1.f1_oe,
               i1.f2_oe, i1.out_oe, i1.r2_sel, i1.r1_en, i1.r2_en, i1.r3_en, i1.f1_f, i1.f2_f};
  assign w3 = {i3.in_ready, i3.busy, i3.out_valid, i3.in0_oe, i3.in1_oe, i3.f1_oe,
               i3.f2_oe, i3.out_oe, i3.r2_sel, i3.r1_en, i3.r2_en, i3.r3_en, i3.f1_f, i3.f2_f};
  assign obs  = sel ? w3 : w1;
  assign excl = (obs[14] & obs[12]) | (obs[13] & obs[11]);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // k = position in the schedule: 0 idle, 1 load, 2..2I+1 execute steps, 2I+2 output.
  int k = 0;

  function automatic logic [17:0] expw(input int pos, input int iters);
    logic rdy, bsy, ov, i0, i1e, f1, f2, oo, r2s, e1, e2, e3;
    logic [3:0] ff1;
    logic [1:0] ff2;
    {rdy, bsy, ov, i0, i1e, f1, f2, oo, r2s, e1, e2, e3} = '0;
    ff1 = 4'd0;
    ff2 = 2'd0;
    if (pos == 0) rdy = 1'b1;
    else begin
      bsy = 1'b1;
      if (pos == 1) begin
        i0 = 1'b1; i1e = 1'b1; e1 = 1'b1; e2 = 1'b1; e3 = 1'b1;
      end else if (pos == 2 * iters + 2) begin
        ov = 1'b1; oo = 1'b1;
      end else if (pos % 2 == 0) begin
        f1 = 1'b1; ff1 = 4'd0; e3 = 1'b1; f2 = 1'b1; ff2 = 2'd0; e2 = 1'b1;
      end else begin
        f1 = 1'b1; ff1 = 4'd1; e1 = 1'b1;
      end
    end
    return {rdy, bsy, ov, i0, i1e, f1, f2, oo, r2s, e1, e2, e3, ff1, ff2};
  endfunction

  task automatic step();
    int iters;
    iters = sel ? 3 : 1;
    @(posedge clk);
    if (rst) k = 0;
    else if (abort && k != 0) k = 0;
    else if (k == 0) begin
      if (start) k = 1;
    end else if (k < 2 * iters + 2) k++;
    else if (out_ready) k = 0;
    #1;
    check_eq($sformatf("ctrl_i%0d_k%0d", iters, k), 32'(obs), 32'(expw(k, iters)));
    check_eq("bus_excl", 32'(excl), 32'd0);
  endtask

  task automatic run_txn(input int cycles);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (cycles) step();
  endtask

  task automatic random_run(input int cycles);
    repeat (cycles) begin
      start     = ($urandom % 3) == 0;
      out_ready = ($urandom % 2) == 0;
      rst       = ($urandom % 50) == 0;
`ifdef ASAP_CU_ABORT_EN
      abort     = ($urandom % 20) == 0;
`endif
      step();
    end
    {start, rst, abort} = '0;
    out_ready = 1'b1;
    repeat (12) step();
  endtask

  initial begin
    // Reset held for two cycles
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Single ITER=1 transaction
    run_txn(5);

    // Output stall for 5 cycles, start during busy ignored
    out_ready = 1'b0;
    start = 1'b1;
    step();
    step();
    step();
    start = 1'b0;
    repeat (6) step();
    out_ready = 1'b1;
    repeat (2) step();

    // Reset during EXEC2, then a clean transaction
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_txn(5);

`ifdef ASAP_CU_ABORT_EN
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    abort = 1'b1;
    step();
    start = 1'b1;
    step();
    {abort, start} = '0;
    repeat (6) step();
`endif

    random_run(300);

    // Switch to the ITER=3 instance
    rst = 1'b1;
    sel = 1'b1;
    step();
    rst = 1'b0;
    run_txn(10);
    random_run(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
